// File: rtl/div_pkg.sv
// Shared types for the divider operand feeder: operand widths, request payload
// and feeder FSM encoding.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned REQ_W      = DIVIDEND_W + DIVISOR_W;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
  } div_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } feed_state_t;

endpackage

// File: rtl/div_operand_feeder_if.sv
// Producer-side valid/ready request channel carrying one dividend/divisor pair.
interface div_operand_feeder_if;
  import div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] in_dividend;
  logic [DIVISOR_W-1:0]  in_divisor;

  modport master (output in_valid, output in_dividend, output in_divisor, input in_ready);
  modport slave  (input in_valid, input in_dividend, input in_divisor, output in_ready);

endinterface

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO; head is read straight from the storage registers so
// a freshly pushed entry becomes visible one cycle after the push.
module div_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      cnt <= cnt + LVL_W'(1);
      else if (!do_push && do_pop) cnt <= cnt - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == LVL_W'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/div_operand_feeder.sv
// Queues dividend/divisor pairs and launches them one at a time into the
// restoring divider, retiring each job on done, error, zero divisor or timeout.
module div_operand_feeder
  import div_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  div_operand_feeder_if.slave    req_if,
  output logic [DIVIDEND_W-1:0]  Dividend,
  output logic [DIVISOR_W-1:0]   Divisor,
  output logic                   div_start,
  input  logic                   div_done,
  input  logic                   div_error,
  output logic                   busy,
  output logic                   job_done,
  output logic                   job_error,
  output logic                   job_zero,
  output logic                   job_timeout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned SC_W = 2;
  localparam int unsigned WD_W = 8;

  feed_state_t     state, state_nxt;
  logic [SC_W-1:0] start_cnt, start_cnt_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            pop_c;
  logic            load_c;
  logic            done_nxt, error_nxt, zero_nxt, timeout_nxt;
  logic            full, empty;
  div_req_t        head;
  div_req_t        push_req;

  assign push_req        = {req_if.in_dividend, req_if.in_divisor};
  assign req_if.in_ready = !full;

  div_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_if.in_valid),
    .pop   (pop_c),
    .wdata (push_req),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Next-state, counters and job outcome decode.
  always_comb begin
    state_nxt     = state;
    start_cnt_nxt = start_cnt;
    wd_cnt_nxt    = wd_cnt;
    pop_c         = 1'b0;
    load_c        = 1'b0;
    done_nxt      = 1'b0;
    error_nxt     = 1'b0;
    zero_nxt      = 1'b0;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop_c = 1'b1;
          if (head.divisor == '0) begin
            zero_nxt = 1'b1;
          end else begin
            load_c        = 1'b1;
            start_cnt_nxt = '0;
            state_nxt     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (start_cnt == SC_W'(START_CYCLES - 1)) begin
          wd_cnt_nxt = '0;
          state_nxt  = WAIT;
        end else begin
          start_cnt_nxt = start_cnt + SC_W'(1);
        end
      end
      WAIT: begin
        wd_cnt_nxt = wd_cnt + WD_W'(1);
        // First WAIT cycle blanks stale flags left over from the previous job.
        if (wd_cnt != '0) begin
          if (div_error) begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end else if (div_done) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      start_cnt   <= '0;
      wd_cnt      <= '0;
      Dividend    <= '0;
      Divisor     <= '0;
      div_start   <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      job_error   <= 1'b0;
      job_zero    <= 1'b0;
      job_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_cnt   <= start_cnt_nxt;
      wd_cnt      <= wd_cnt_nxt;
      div_start   <= (state_nxt == LAUNCH);
      busy        <= (state_nxt != IDLE);
      job_done    <= done_nxt;
      job_error   <= error_nxt;
      job_zero    <= zero_nxt;
      job_timeout <= timeout_nxt;
      if (load_c) begin
        Dividend <= head.dividend;
        Divisor  <= head.divisor;
      end
    end
  end

endmodule

// File: tb/tb_div_operand_feeder.sv
// Randomized scoreboard bench for div_operand_feeder with a behavioural divider
// that plays back a per-job response plan chosen when the pair is issued.
module tb_div_operand_feeder;
  import div_pkg::*;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned START_CYCLES = 2;
  localparam int unsigned TIMEOUT      = 64;
  localparam int unsigned LVL_W        = $clog2(DEPTH) + 1;

  localparam int K_DONE    = 0;
  localparam int K_ERROR   = 1;
  localparam int K_ZERO    = 2;
  localparam int K_TIMEOUT = 3;

  // resp: 0 done, 1 error, 2 error+done together, 3 silent
  typedef struct {
    int              resp;
    int              k;
    bit              stale;
    logic [15:0]     dd;
    logic [7:0]      dv;
  } plan_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             div_done = 1'b0;
  logic             div_error = 1'b0;
  logic [15:0]      Dividend;
  logic [7:0]       Divisor;
  logic             div_start;
  logic             busy;
  logic             job_done, job_error, job_zero, job_timeout;
  logic [LVL_W-1:0] level;

  div_operand_feeder_if bus();

  div_operand_feeder #(
    .DEPTH        (DEPTH),
    .START_CYCLES (START_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (bus),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .div_start   (div_start),
    .div_done    (div_done),
    .div_error   (div_error),
    .busy        (busy),
    .job_done    (job_done),
    .job_error   (job_error),
    .job_zero    (job_zero),
    .job_timeout (job_timeout),
    .level       (level)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    launches = 0;
  int    exp_q[$];
  plan_t plan_q[$];
  int    tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one pair; caller is at posedge+1. Expectations are queued on acceptance.
  task automatic push_pair(input logic [15:0] dd, input logic [7:0] dv,
                           input int resp, input int k, input bit stale);
    int    g;
    plan_t p;
    g = 0;
    while (!bus.in_ready && g < 2000) begin
      @(posedge clk); #1; g++;
    end
    if (!bus.in_ready) begin
      chk("push_accept_in_time", 32'(g), 0);
      return;
    end
    bus.in_valid    = 1'b1;
    bus.in_dividend = dd;
    bus.in_divisor  = dv;
    if (dv == 8'd0) begin
      exp_q.push_back(K_ZERO);
    end else begin
      exp_q.push_back(resp == 0 ? K_DONE : (resp == 3 ? K_TIMEOUT : K_ERROR));
      p = '{resp: resp, k: k, stale: stale, dd: dd, dv: dv};
      plan_q.push_back(p);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 5000) begin
      @(posedge clk); #1; g++;
    end
    chk("drain_in_time", 32'(g < 5000), 1);
  endtask

  // Behavioural divider: responds to each launch according to its plan.
  initial begin : divider
    bit    launching, waiting;
    int    slen, kk;
    plan_t cur;
    launching = 0; waiting = 0; slen = 0; kk = 0;
    cur = '{resp: 3, k: 0, stale: 0, dd: 16'd0, dv: 8'd0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        launching = 0; waiting = 0;
        div_done = 1'b0; div_error = 1'b0;
      end else if (div_start) begin
        if (!launching) begin
          launching = 1; waiting = 0; slen = 0; launches++;
          chk("launch_expected", 32'(plan_q.size() > 0), 1);
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            chk("dividend_at_launch", 32'(Dividend), 32'(cur.dd));
            chk("divisor_at_launch", 32'(Divisor), 32'(cur.dv));
          end else begin
            cur = '{resp: 3, k: 0, stale: 0, dd: 16'd0, dv: 8'd0};
          end
          if (!cur.stale) begin
            div_done = 1'b0; div_error = 1'b0;
          end
        end
        slen++;
      end else if (launching) begin
        launching = 0;
        chk("start_length", 32'(slen), START_CYCLES);
        waiting = 1; kk = 0;
        tq.push_back(cur.resp == 3 ? cyc + int'(TIMEOUT) : cyc + cur.k + 1);
      end else if (waiting) begin
        kk++;
        if (kk == 1) begin
          div_done = 1'b0; div_error = 1'b0;
        end
        if (cur.resp != 3 && kk == cur.k) begin
          div_done  = (cur.resp != 1);
          div_error = (cur.resp != 0);
          waiting   = 0;
        end
        if (kk >= int'(TIMEOUT)) waiting = 0;
      end
    end
  end

  // Monitor: every job pulse retires the oldest outstanding pair.
  initial begin : monitor
    int np, act, e, t;
    forever begin
      @(negedge clk);
      if (reset) begin
        np = int'(job_done) + int'(job_error) + int'(job_zero) + int'(job_timeout);
        if (np > 0) begin
          chk("single_pulse", 32'(np), 1);
          act = job_done ? K_DONE : job_error ? K_ERROR : job_zero ? K_ZERO : K_TIMEOUT;
          chk("pulse_has_pending_job", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("job_kind", 32'(act), 32'(e));
            if (e != K_ZERO) begin
              chk("pulse_has_timing", 32'(tq.size() > 0), 1);
              if (tq.size() > 0) begin
                t = tq.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(t));
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int l0, r, resp, k, gap;
    logic [7:0] dv;
    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_dividend", 32'(Dividend), 0);
    chk("rst_divisor", 32'(Divisor), 0);
    chk("rst_pulses", 32'({job_done, job_error, job_zero, job_timeout}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // basic job completing with done
    push_pair(16'd100, 8'd7, 0, 3, 0);
    wait_idle();
    chk("level_after_job", 32'(level), 0);
    chk("launch_count", 32'(launches), 1);

    // zero divisor dropped without launch
    l0 = launches;
    push_pair(16'd500, 8'd0, 0, 1, 0);
    wait_idle();
    chk("zero_no_launch", 32'(launches), 32'(l0));
    chk("zero_keeps_dividend", 32'(Dividend), 100);
    chk("zero_keeps_divisor", 32'(Divisor), 7);

    // five back-to-back with a silent divider
    for (int i = 0; i < 5; i++) push_pair(16'(1000 + i), 8'(i + 1), 3, 0, 0);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_level", 32'(level), DEPTH);
    wait_idle();

    // stale done held into next launch, then error and done together
    push_pair(16'd300, 8'd5, 0, 4, 0);
    push_pair(16'd301, 8'd6, 0, 2, 1);
    push_pair(16'd302, 8'd9, 2, 3, 0);
    push_pair(16'd303, 8'd3, 3, 0, 1);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      dv   = ($urandom % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      r    = $urandom % 10;
      resp = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      k    = $urandom_range(1, 10);
      push_pair(16'($urandom), dv, resp, k, 1'($urandom % 2));
    end
    wait_idle();
    chk("level_after_random", 32'(level), 0);

    // asynchronous reset during WAIT with three queued
    for (int i = 0; i < 4; i++) push_pair(16'(2000 + i), 8'(i + 2), 3, 0, 0);
    begin
      int g;
      g = 0;
      while (!(busy && !div_start) && g < 200) begin @(posedge clk); #1; g++; end
    end
    chk("pre_reset_level", 32'(level), 3);
    chk("pre_reset_busy", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_div_start", 32'(div_start), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_level", 32'(level), 0);
    exp_q.delete(); plan_q.delete(); tq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_level", 32'(level), 0);
    push_pair(16'd42, 8'd6, 0, 2, 0);
    wait_idle();
    chk("all_jobs_retired", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
